// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: IF/ID boundary FIFO. It captures completed fetches,
// acknowledges the fetcher, and presents the selected 32-bit instruction
// half to the decoder through a valid/ready handshake. It also owns the
// sequential fetch PC.
module fetch_decode_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetcher_done,
    input  logic [63:0]                instruction_in,
    input  logic [63:0]                fetch_address,
    input  logic                       jump_reset,
    input  logic [63:0]                jump_target,
    output logic                       if_id_pipeline_valid,
    output logic [63:0]                pc_current,
    output logic                       id_valid,
    output logic [31:0]                id_instruction,
    output logic [63:0]                id_pc,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [63:0]   r_word [DEPTH];
    logic [63:0]   r_addr [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_ack;
    logic [63:0]   r_pc;

    logic          w_pop;
    logic          w_push;
    logic [63:0]   w_headWord;
    logic [63:0]   w_headAddr;

    // The pop is derived from the registered count, so id_ready only steers
    // state at the edge; the acknowledge stays purely registered.
    assign w_pop  = id_valid && id_ready;

    // The acknowledge term blocks a second capture while the fetcher is still
    // lowering done, and a pop can make room in a full FIFO for this push.
    assign w_push = fetcher_done && !r_ack && !jump_reset &&
                    ((r_count < FULL_COUNT) || w_pop);

    assign w_headWord = r_word[r_rdPtr];
    assign w_headAddr = r_addr[r_rdPtr];

    assign id_valid             = (r_count != '0);
    assign id_instruction       = w_headAddr[2] ? w_headWord[63:32] : w_headWord[31:0];
    assign id_pc                = w_headAddr;
    assign occupancy            = r_count;
    assign if_id_pipeline_valid = r_ack;
    assign pc_current           = r_pc;

    // Entry storage. Contents are don't-care after reset or a flush, so the
    // array is left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word[r_wrPtr] <= instruction_in;
            r_addr[r_wrPtr] <= fetch_address;
        end
    end

    // Pointers, count, acknowledge and PC. A flush wins over both push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_pc    <= RESET_PC;
        end else if (jump_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_pc    <= jump_target;
        end else begin
            r_ack <= w_push;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                r_pc    <= fetch_address + 64'd4;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
